noc_rr_arbiter3: RTL

- Three-input round-robin packet arbiter for one router output port.
- Sits directly upstream of the router's registered 3:1 output multiplexer and drives that mux's 2-bit select (2'b00 = input 1, 2'b01 = input 2, 2'b10 = input 3, 2'b11 = none).
- Grants whole packets: one input holds the output from the first granted flit until its tail flit transfers. A hold-limit watchdog force-releases a stuck grant.

---
 rtl/noc_rr_arbiter3.sv | 125 ++++++++++++
 1 files changed

// File: rtl/noc_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter3
//   Three-input round-robin packet arbiter for one router output port. It
//   drives the select of the downstream registered 3:1 output mux. A grant
//   covers a whole packet: the winning input keeps the output from its first
//   flit until its tail flit transfers. A hold watchdog force-releases a grant
//   that has been locked for MAX_HOLD cycles without a tail transfer.
//
// Ports
//   clk           : system clock, all state on rising edge
//   reset         : synchronous, active-high reset
//   req[2:0]      : input i has a flit available
//   tail[2:0]     : flit presented by input i is its packet's last (needs req[i])
//   out_ready     : downstream accepts a flit this cycle
//   select[1:0]   : mux select, 00/01/10 = input 1/2/3, 11 = no grant
//   grant[2:0]    : registered one-hot grant, 000 when idle
//   pop[2:0]      : combinational dequeue strobe = grant & req & out_ready
//   release_abort : one-cycle pulse following a watchdog forced release
// -----------------------------------------------------------------------------
module noc_rr_arbiter3 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] tail,
  input  logic       out_ready,
  output logic [1:0] select,
  output logic [2:0] grant,
  output logic [2:0] pop,
  output logic       release_abort
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [2:0]       r_grant;
  logic [1:0]       r_select;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;

  logic [1:0]       w_pick;
  logic [2:0]       w_pick_oh;
  logic             w_tail_xfer;

  // Round-robin pick: scan circularly starting after the last winner.
  // Returns the winning index, or 2'b11 when nobody requests.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c0, c1, c2;
    c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (r[c0])      rr_pick = c0;
    else if (r[c1]) rr_pick = c1;
    else if (r[c2]) rr_pick = c2;
    else            rr_pick = 2'b11;
  endfunction

  assign w_pick    = rr_pick(req, r_last);
  assign w_pick_oh = (w_pick == 2'b11) ? 3'b000 : 3'(3'b001 << w_pick);

  // Pop is suppressed during a reset cycle so a dropped grant never dequeues.
  assign pop         = r_grant & req & {3{out_ready}} & {3{~reset}};
  assign w_tail_xfer = |(pop & tail);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= 3'b000;
      r_select <= 2'b11;
      r_last   <= 2'd2;
      r_cnt    <= '0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          r_cnt   <= '0;
          if (w_pick != 2'b11) begin
            r_state  <= S_LOCKED;
            r_grant  <= w_pick_oh;
            r_select <= w_pick;
          end
        end
        S_LOCKED: begin
          if (w_tail_xfer) begin
            // Normal release wins even when the counter is at its limit.
            r_state  <= S_IDLE;
            r_last   <= r_select;
            r_grant  <= 3'b000;
            r_select <= 2'b11;
            r_abort  <= 1'b0;
          end else if (r_cnt == LIMIT) begin
            r_state  <= S_IDLE;
            r_last   <= r_select;
            r_grant  <= 3'b000;
            r_select <= 2'b11;
            r_abort  <= 1'b1;
          end else begin
            r_abort <= 1'b0;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_grant  <= 3'b000;
          r_select <= 2'b11;
          r_abort  <= 1'b0;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign select        = r_select;
  assign release_abort = r_abort;

endmodule
